// File: rtl/digital_tube_driver_if.sv
// Display bus between a value source and the 8-digit 7-segment driver.
// The source drives the value and enable; the driver returns the pin drive.
interface digital_tube_driver_if;
  logic [31:0] disp_data;
  logic        en;
  logic [6:0]  seg;
  logic [7:0]  sel;

  modport master (output disp_data, output en, input seg, input sel);
  modport slave  (input disp_data, input en, output seg, output sel);
endinterface

// File: rtl/digital_tube_driver.sv
// Multiplexed driver for an 8-digit, 7-segment display (active-low pins).
// A free-running divider advances the digit index every DIV clocks; the
// segment/select outputs are registered from the current index, so a new
// digit appears one edge after the index moves.
module digital_tube_driver #(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int SCAN_FREQ = 1000
) (
  input logic                  clk,
  input logic                  rst,
  digital_tube_driver_if.slave bus
);
  localparam int DIV = CLK_FREQ / SCAN_FREQ;
  localparam int CW  = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);

  // Hex nibble to active-low segments, {g,f,e,d,c,b,a}.
  function automatic logic [6:0] hex7(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  logic [CW-1:0] div_cnt_q, div_cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [6:0]    seg_q, seg_d;
  logic [7:0]    sel_q, sel_d;
  logic [3:0]    nib;
  logic          wrap;

  // Scan timing: divider wraps every DIV clocks and bumps the digit index.
  // The scan runs independently of the enable.
  always_comb begin
    wrap      = (div_cnt_q == DIV_LAST);
    div_cnt_d = wrap ? '0 : div_cnt_q + 1'b1;
    idx_d     = wrap ? idx_q + 3'd1 : idx_q;
  end

  // Output drive for the currently indexed digit, or all dark when disabled.
  // disp_data is not latched; the live nibble is decoded every clock.
  always_comb begin
    nib   = bus.disp_data[{idx_q, 2'b00} +: 4];
    sel_d = 8'hFF;
    seg_d = 7'h7F;
    if (bus.en) begin
      sel_d = ~(8'b1 << idx_q);
      seg_d = hex7(nib);
    end
  end

  // State and output registers; reset wins over everything, even mid-digit.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_q <= '0;
      idx_q     <= '0;
      sel_q     <= 8'hFF;
      seg_q     <= 7'h7F;
    end else begin
      div_cnt_q <= div_cnt_d;
      idx_q     <= idx_d;
      sel_q     <= sel_d;
      seg_q     <= seg_d;
    end
  end

  assign bus.sel = sel_q;
  assign bus.seg = seg_q;
endmodule

// File: tb/tb_digital_tube_driver.sv
// Directed bench for digital_tube_driver at DIV=8 (800 Hz clock, 100 Hz scan).
module tb_digital_tube_driver;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  digital_tube_driver_if bus();

  digital_tube_driver #(.CLK_FREQ(800), .SCAN_FREQ(100)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks   = 0;
  int failures = 0;

  // Select per digit and segment codes for 0x01234567 / 0x89ABCDEF, digit 0 first.
  logic [7:0] sel_t [8] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
  logic [6:0] seg_a [8] = '{7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40};
  logic [6:0] seg_b [8] = '{7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00};

  // Advance one edge and settle before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.en = 1'b1;
    bus.disp_data = 32'h0;
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if (bus.sel !== 8'hFF || bus.seg !== 7'h7F) begin
        failures++;
        $display("FAIL reset cyc=%0d sel=%h seg=%h want sel=ff seg=7f", i, bus.sel, bus.seg);
      end
    end
  endtask

  // Two full frames starting from the first edge after reset release.
  task automatic test_scan();
    bus.disp_data = 32'h01234567;
    rst = 1'b0;
    for (int f = 0; f < 2; f++)
      for (int d = 0; d < 8; d++)
        for (int c = 0; c < 8; c++) begin
          tick();
          checks++;
          if (bus.sel !== sel_t[d] || bus.seg !== seg_a[d]) begin
            failures++;
            $display("FAIL scan f=%0d d=%0d c=%0d sel=%h seg=%h want sel=%h seg=%h",
                     f, d, c, bus.sel, bus.seg, sel_t[d], seg_a[d]);
          end
        end
  endtask

  // Data changes while digit 0 is lit; it must update on the very next edge.
  task automatic test_hex_letters();
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (bus.sel !== 8'hFE || bus.seg !== 7'h78) begin
        failures++;
        $display("FAIL hex_pre c=%0d sel=%h seg=%h want sel=fe seg=78", c, bus.sel, bus.seg);
      end
    end
    bus.disp_data = 32'h89ABCDEF;
    for (int d = 0; d < 8; d++)
      for (int c = (d == 0) ? 3 : 0; c < 8; c++) begin
        tick();
        checks++;
        if (bus.sel !== sel_t[d] || bus.seg !== seg_b[d]) begin
          failures++;
          $display("FAIL hex d=%0d c=%0d sel=%h seg=%h want sel=%h seg=%h",
                   d, c, bus.sel, bus.seg, sel_t[d], seg_b[d]);
        end
      end
  endtask

  // Blank mid-digit for 10 clocks, then resume at the free-running digit.
  task automatic test_enable();
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (bus.sel !== 8'hFE || bus.seg !== 7'h0E) begin
        failures++;
        $display("FAIL en_pre c=%0d sel=%h seg=%h want sel=fe seg=0e", c, bus.sel, bus.seg);
      end
    end
    bus.en = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      checks++;
      if (bus.sel !== 8'hFF || bus.seg !== 7'h7F) begin
        failures++;
        $display("FAIL en_off c=%0d sel=%h seg=%h want sel=ff seg=7f", c, bus.sel, bus.seg);
      end
    end
    // 13 edges into the frame: digit 1 has 3 edges of its dwell left.
    bus.en = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (bus.sel !== 8'hFD || bus.seg !== 7'h06) begin
        failures++;
        $display("FAIL en_on c=%0d sel=%h seg=%h want sel=fd seg=06", c, bus.sel, bus.seg);
      end
    end
    tick();
    checks++;
    if (bus.sel !== 8'hFB || bus.seg !== 7'h21) begin
      failures++;
      $display("FAIL en_next sel=%h seg=%h want sel=fb seg=21", bus.sel, bus.seg);
    end
  endtask

  // Run into digit 5 (17 edges into the frame so far), then pulse reset.
  task automatic test_reset_mid();
    for (int c = 0; c < 26; c++) tick();
    checks++;
    if (bus.sel !== 8'hDF || bus.seg !== 7'h08) begin
      failures++;
      $display("FAIL mid_pre sel=%h seg=%h want sel=df seg=08", bus.sel, bus.seg);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (bus.sel !== 8'hFF || bus.seg !== 7'h7F) begin
      failures++;
      $display("FAIL mid_rst sel=%h seg=%h want sel=ff seg=7f", bus.sel, bus.seg);
    end
    for (int c = 0; c < 8; c++) begin
      tick();
      checks++;
      if (bus.sel !== 8'hFE || bus.seg !== 7'h0E) begin
        failures++;
        $display("FAIL mid_dwell c=%0d sel=%h seg=%h want sel=fe seg=0e", c, bus.sel, bus.seg);
      end
    end
    tick();
    checks++;
    if (bus.sel !== 8'hFD || bus.seg !== 7'h06) begin
      failures++;
      $display("FAIL mid_next sel=%h seg=%h want sel=fd seg=06", bus.sel, bus.seg);
    end
  endtask

  // Three frames from edge 10 after the reset pulse: sequence and one-low invariant.
  task automatic test_wrap();
    int         di;
    logic [7:0] exp_sel;
    for (int k = 10; k < 10 + 3 * 64; k++) begin
      tick();
      di      = ((k - 1) / 8) % 8;
      exp_sel = sel_t[di];
      checks++;
      if (bus.sel !== exp_sel || bus.seg !== seg_b[di]) begin
        failures++;
        $display("FAIL wrap k=%0d sel=%h seg=%h want sel=%h seg=%h",
                 k, bus.sel, bus.seg, exp_sel, seg_b[di]);
      end
      checks++;
      if ($countones(~bus.sel) != 1) begin
        failures++;
        $display("FAIL onehot k=%0d sel=%h want exactly one low bit", k, bus.sel);
      end
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_hex_letters();
    test_enable();
    test_reset_mid();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/digital_tube_driver.md
# digital_tube_driver

Multiplexed driver for an 8-digit, 7-segment LED display. Shows a 32-bit value as eight hexadecimal digits. Time-multiplexes one digit at a time at a fixed scan rate derived from the system clock. Sits between any register holding a display value and the board's segment/digit-select pins.

## Interface

Reset is synchronous and active-high. The block uses one clock, `clk`, and one reset, `rst`.

Parameters:
- `CLK_FREQ`, default 50_000_000: system clock frequency in Hz.
- `SCAN_FREQ`, default 1000: digit-switch rate in Hz. `DIV = CLK_FREQ/SCAN_FREQ` clocks per digit; the default is 50000. `DIV` must be ≥ 2.

Ports:
- `clk`, input, 1 bit: system clock. All logic is on its rising edge.
- `rst`, input, 1 bit: synchronous reset, active-high.
- `disp_data`, input, 32 bits: eight hex nibbles. `disp_data[4k+3:4k]` is shown on digit k. Digit 0 is rightmost, digit 7 is leftmost.
- `en`, input, 1 bit: display enable. 1 = display on, 0 = all digits blank.
- `seg`, output, 7 bits: segment drive, active-low. Bit mapping is `seg[0]`=a, `seg[1]`=b, `seg[2]`=c, `seg[3]`=d, `seg[4]`=e, `seg[5]`=f, `seg[6]`=g. No decimal point.
- `sel`, output, 8 bits: digit select, one-hot, active-low. `sel[k]=0` enables digit k.

## Operation

- **Divider.** `div_cnt` counts 0..DIV-1 and wraps to 0.
  - When `div_cnt==DIV-1`, digit index `idx` (3 bits) increments modulo 8 (7→0).
- **Free-running scan.** The divider and `idx` run regardless of `en`; `en` affects only the outputs.
- **Outputs when `en=1`:**
  - `sel <= ~(8'b1 << idx)`.
  - `seg <= hex7(disp_data[4*idx+3 -: 4])`.
- **Outputs when `en=0`:** `sel <= 8'hFF` and `seg <= 7'h7F`.
- **`hex7` encoding**, active-low, value shown as {g..a}:
  - 0→40, 1→79, 2→24, 3→30, 4→19, 5→12, 6→02, 7→78
  - 8→00, 9→10, A→08, b→03, C→46, d→21, E→06, F→0E
- **Reset.** While `rst=1` at a clock edge:
  - `div_cnt=0`, `idx=0`, `sel=8'hFF`, `seg=7'h7F`.
  - Reset has priority over `en` and the divider, including when asserted in the middle of a digit period.
- **`disp_data` sampling.** `disp_data` is sampled every clock, with no latching. A change updates the displayed digit on the next edge; other digits update when they are next scanned.

## Timing

- `seg` and `sel` are registered and have 1-cycle latency from `idx`, `en` and `disp_data`.
- **First edge after reset release.** `idx=0` and `div_cnt` advances to 1. The outputs register idx 0, so `sel=8'hFE`.
- **Digit dwell.** Each digit is selected for exactly DIV clocks.
- **Digit advance.** On the edge where `div_cnt` wraps, `idx` advances. `sel` shows the new digit on the following edge, so there is one extra cycle of old digit, which is acceptable.
- **Frame period.** 8·DIV clocks, which is 8 ms at the defaults. Refresh is 125 Hz per digit.
- **`en` toggle.** Output blanks or unblanks 1 cycle after `en` changes. The scan phase is unaffected.
- **`sel` invariant.** Exactly one `sel` bit is 0 when enabled. No cycle ever has two or more `sel` bits at 0.

## Test plan

Simulation sets CLK_FREQ=800 and SCAN_FREQ=100, giving DIV=8.

1. **Reset values.** Hold `rst=1` for 20 clocks with `en=1` and `disp_data=0` → `sel=8'hFF` and `seg=7'h7F` throughout.
2. **Scan sequence.** Release reset with `disp_data=32'h01234567` → `sel` steps FE, FD, FB, F7, EF, DF, BF, 7F, each for 8 clocks, then repeats. `seg` follows 78, 02, 12, 19, 30, 24, 79, 40.
3. **Hex letters.** Set `disp_data=32'h89ABCDEF` → digits 0..7 show `seg` 0E, 06, 21, 46, 03, 08, 10, 00. Digit 0's value changes within 1 cycle if it is currently selected.
4. **Enable.** Drop `en` to 0 mid-digit → next cycle `sel=8'hFF` and `seg=7'h7F`. Restore `en=1` → the display resumes at the digit the free-running `idx` has reached.
5. **Reset mid-scan.** Pulse `rst` for 1 cycle while `idx=5` → outputs blank on the next edge. The scan then restarts at digit 0 with a full 8-clock dwell.
6. **Wrap check.** Run 3 full frames → `idx` wraps 7→0 cleanly, and at most one `sel` bit is ever low.
